// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 control block.
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - exception codes recorded in Cause.ExcCode
//   - default handler entry address and PRId contents
//   - bit positions of the SR and Cause fields
//   - victim_epc(): return address for an exception/interrupt
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] PRID_DEF       = 32'h2024_0001;

  localparam int unsigned SR_IM_HI     = 15;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IE        = 0;
  localparam int unsigned CAUSE_BD     = 31;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_EXC_LO = 2;

  // A delay-slot victim restarts at its branch, one word earlier (wraps mod 2^32).
  function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 control beside the M stage of the MIPS pipeline.
// Holds SR, Cause, EPC and PRId, services mfc0/mtc0/eret and raises Req,
// the flush/redirect request for interrupts and M-stage exceptions.
//
// Ports:
//   clk        pipeline clock, rising edge
//   reset      asynchronous, active-low; clears all state and forces Req=0
//   A1         mfc0 read register number
//   A2         mtc0 write register number
//   DIn        mtc0 write data
//   WE         mtc0 write enable (M stage)
//   PCM        PC of the M-stage instruction
//   BDM        M-stage instruction sits in a branch delay slot
//   ExcCodeM   exception code carried to M (0 = none)
//   EXLClr     eret in M stage
//   HWInt      level-sensitive hardware interrupt lines
//   Req        take exception/interrupt this cycle (combinational)
//   DOut       mfc0 read data (combinational)
//   EPCOut     current EPC, eret target
//   HandlerPC  exception entry address (constant)
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = PRID_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic [4:0]  ExcCodeM,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (ExcCodeM != EXC_INT) & ~sr_exl;
  // Gating with reset lets an asserted reset kill a request mid-cycle.
  assign Req     = reset & (int_req | exc_req);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (Req) begin
        // The victim did not complete, so its mtc0/eret side effects are dropped.
        sr_exl    <= 1'b1;
        cause_bd  <= BDM;
        cause_exc <= int_req ? EXC_INT : ExcCodeM;
        epc       <= victim_epc(PCM, BDM);
      end else begin
        if (WE && (A2 == REG_SR)) begin
          sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
          sr_exl <= DIn[SR_EXL];
          sr_ie  <= DIn[SR_IE];
        end
        if (WE && (A2 == REG_EPC)) begin
          epc <= DIn;
        end
        // Placed after the SR write so eret overrides the written EXL bit.
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_word                              = '0;
    sr_word[SR_IM_HI:SR_IM_LO]           = sr_im;
    sr_word[SR_EXL]                      = sr_exl;
    sr_word[SR_IE]                       = sr_ie;
    cause_word                           = '0;
    cause_word[CAUSE_BD]                 = cause_bd;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]  = cause_ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
  end

  always_comb begin
    DOut = '0;
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc;
      REG_PRID:  DOut = PRID_VAL;
      default:   DOut = '0;
    endcase
  end

  assign EPCOut    = epc;
  assign HandlerPC = HANDLER_PC;

endmodule
